// File: rtl/ibuf_deglitch.sv
// Pad input receiver: IBUF, multi-stage synchronizer and a programmable
// glitch filter with rise/fall/glitch strobes and a saturating glitch counter.

`ifndef SYNTHESIS
// Behavioural stand-in for the vendor input buffer, used only outside synthesis.
module IBUF #(
    parameter CAPACITANCE  = "DONT_CARE",
    parameter IBUF_LOW_PWR = "TRUE",
    parameter IOSTANDARD   = "DEFAULT"
) (
    output logic O,
    input  logic I
);
    // Buffer attributes only shape silicon delay/power; logically a wire.
    localparam bit ATTR_SET = (CAPACITANCE != "") && (IBUF_LOW_PWR != "") && (IOSTANDARD != "");
    assign O = ATTR_SET ? I : I;
endmodule
`endif

module ibuf_deglitch #(
    parameter     CAPACITANCE  = "DONT_CARE",
    parameter     IBUF_LOW_PWR = "TRUE",
    parameter     IOSTANDARD   = "DEFAULT",
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_BITS  = 4,
    parameter bit INIT         = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   I,
    input  logic                   en,
    input  logic [FILTER_BITS-1:0] filt_len,
    input  logic                   glitch_clr,
    output logic                   sync_o,
    output logic                   dout,
    output logic                   rise,
    output logic                   fall,
    output logic                   glitch,
    output logic [7:0]             glitch_cnt
);

    logic pad_buf;

    IBUF #(
        .CAPACITANCE  (CAPACITANCE),
        .IBUF_LOW_PWR (IBUF_LOW_PWR),
        .IOSTANDARD   (IOSTANDARD)
    ) u_ibuf (
        .O (pad_buf),
        .I (I)
    );

    // Saturating increment for the 8-bit glitch counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // --- stage p0..pN: synchronizer chain into clk domain ---
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_p;

    // Shift the buffered pad level through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p <= {SYNC_STAGES{INIT}};
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], pad_buf};
        end
    end

    assign sync_o = sync_p[SYNC_STAGES-1];

    // --- filter stage: accept after filt_len+1 consecutive differing samples ---
    logic [FILTER_BITS-1:0] cnt;
    logic                   differ;
    logic                   glitch_now;

    assign differ     = (sync_o != dout);
    assign glitch_now = en && !differ && (cnt != '0);

    // Filter counter, debounced level and one-cycle strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout   <= INIT;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            glitch <= 1'b0;
        end else begin
            rise   <= 1'b0;
            fall   <= 1'b0;
            glitch <= 1'b0;
            if (!en) begin
                // Disabling abandons any pending change silently.
                cnt <= '0;
            end else if (differ) begin
                if (cnt == filt_len) begin
                    dout <= sync_o;
                    cnt  <= '0;
                    rise <= sync_o;
                    fall <= !sync_o;
                end else begin
                    // Wraps if filt_len was lowered below cnt, so it never locks up.
                    cnt <= cnt + 1'b1;
                end
            end else if (cnt != '0) begin
                cnt    <= '0;
                glitch <= 1'b1;
            end
        end
    end

    // Glitch counter; a clear in the same cycle as a glitch wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_cnt <= 8'd0;
        end else if (glitch_clr) begin
            glitch_cnt <= 8'd0;
        end else if (glitch_now) begin
            glitch_cnt <= sat_inc8(glitch_cnt);
        end
    end

endmodule
